// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out handshake bundle for uart_word_packer.
// master = byte source + word consumer, slave = the packer itself.
interface uart_word_packer_if;
    logic        rxd_data_ready;
    logic [7:0]  rxd_data;
    logic        rxd_endofpacket;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        fifo_full;
    logic        overflow;
    logic        seq_err;
    logic [7:0]  pkt_sum;
    logic        pkt_sum_valid;

    modport master (
        output rxd_data_ready, rxd_data, rxd_endofpacket, word_ready,
        input  word_valid, word_data, word_last, fifo_full, overflow, seq_err,
               pkt_sum, pkt_sum_valid
    );

    modport slave (
        input  rxd_data_ready, rxd_data, rxd_endofpacket, word_ready,
        output word_valid, word_data, word_last, fifo_full, overflow, seq_err,
               pkt_sum, pkt_sum_valid
    );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes little-endian into 32-bit words, flushes partial words at end of packet,
// and queues them in a show-ahead FIFO. Define UART_PKT_CHECKSUM_EN for the per-packet sum.
module uart_word_packer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input logic               clk,
    input logic               rst,
    uart_word_packer_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ASM, FLUSH1, FLUSH2} state_e;

    state_e          state_q;
    logic [1:0]      lane_q;
    logic [31:0]     asm_q;
    logic [31:0]     pend_q;
    logic            pend_vld_q;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic            overflow_q, seq_err_q;

    logic            byte_acc, eop_acc;
    logic [31:0]     word_full, word_part, push_data;
    logic            push, push_last, push_ok, pop, full;

    assign byte_acc  = (state_q == ASM) && bus.rxd_data_ready;
    assign eop_acc   = (state_q == ASM) && !bus.rxd_data_ready && bus.rxd_endofpacket;
    assign word_full = {bus.rxd_data, asm_q[23:0]};
    assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop       = (cnt_q != '0) && bus.word_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push && (!full || pop);

    always_comb begin
        for (int i = 0; i < 4; i++)
            word_part[8*i +: 8] = (i < int'(lane_q)) ? asm_q[8*i +: 8] : PAD_BYTE;
    end

    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        push_data = pend_q;
        case (state_q)
            ASM: begin
                if (byte_acc && lane_q == 2'd3 && pend_vld_q) push = 1'b1;
                if (eop_acc && pend_vld_q && lane_q == 2'd0) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                end
            end
            FLUSH1: push = 1'b1;
            FLUSH2: begin
                push      = 1'b1;
                push_last = 1'b1;
                push_data = word_part;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ASM;
            lane_q     <= '0;
            asm_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ASM: begin
                    if (byte_acc) begin
                        asm_q[{lane_q, 3'b000} +: 8] <= bus.rxd_data;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            pend_q     <= word_full;
                            pend_vld_q <= 1'b1;
                        end
                    end else if (eop_acc) begin
                        if (pend_vld_q && lane_q != 2'd0) state_q <= FLUSH1;
                        else if (pend_vld_q)              pend_vld_q <= 1'b0;
                        else if (lane_q != 2'd0)          state_q <= FLUSH2;
                    end
                end
                FLUSH1: begin
                    pend_vld_q <= 1'b0;
                    state_q    <= FLUSH2;
                end
                FLUSH2: begin
                    lane_q  <= '0;
                    state_q <= ASM;
                end
                default: state_q <= ASM;
            endcase

            if (state_q != ASM && bus.rxd_data_ready) seq_err_q <= 1'b1;
            if (push && full && !pop) overflow_q <= 1'b1;

            if (push_ok) begin
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Word storage needs no reset: the head is masked until the count says it is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign bus.word_valid = (cnt_q != '0);
    assign bus.word_data  = bus.word_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.word_last  = bus.word_valid & last_q[rd_ptr_q];
    assign bus.fifo_full  = full;
    assign bus.overflow   = overflow_q;
    assign bus.seq_err    = seq_err_q;

`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       sum_fire;

    // Fires on the last=1 push, or on an end of packet that carried no bytes at all.
    assign sum_fire = (push && push_last) || (eop_acc && !pend_vld_q && lane_q == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sum_q <= '0;
        else if (sum_fire) sum_q <= '0;
        else if (byte_acc) sum_q <= sum_q + bus.rxd_data;
    end

    assign bus.pkt_sum       = sum_fire ? sum_q : 8'h00;
    assign bus.pkt_sum_valid = sum_fire;
`else
    assign bus.pkt_sum       = 8'h00;
    assign bus.pkt_sum_valid = 1'b0;
`endif
endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer (FIFO_DEPTH=8, PAD_BYTE=00); popped words are logged
// on the falling edge and compared against hand-computed words.
module tb_uart_word_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_word_packer_if bus();

    uart_word_packer #(.FIFO_DEPTH(8), .PAD_BYTE(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sumv_n = 0;
    logic [7:0] sumv_v = 8'h00;
    logic [31:0] mq_d [$];
    logic        mq_l [$];
    int          mq_c [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.word_valid && bus.word_ready) begin
            mq_d.push_back(bus.word_data);
            mq_l.push_back(bus.word_last);
            mq_c.push_back(cyc);
        end
        if (bus.pkt_sum_valid) begin
            sumv_n++;
            sumv_v = bus.pkt_sum;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rxd_data       = b;
        bus.rxd_data_ready = 1'b1;
        tick(1);
        bus.rxd_data_ready = 1'b0;
    endtask

    task automatic send_eop();
        bus.rxd_endofpacket = 1'b1;
        tick(1);
        bus.rxd_endofpacket = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        mq_d.delete();
        mq_l.delete();
        mq_c.delete();
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic l, output int c);
        c = -1;
        if (mq_d.size() > 0) begin
            chk({tag, "_data"}, mq_d.pop_front(), d);
            chk({tag, "_last"}, mq_l.pop_front(), l);
            c = mq_c.pop_front();
        end
    endtask

    initial begin
        int c, e;
        rst = 1'b1;
        bus.rxd_data_ready  = 1'b0;
        bus.rxd_data        = 8'h00;
        bus.rxd_endofpacket = 1'b0;
        bus.word_ready      = 1'b1;
        tick(2);
        chk("rst_valid",    bus.word_valid, 1'b0);
        chk("rst_data",     bus.word_data, 32'h0);
        chk("rst_last",     bus.word_last, 1'b0);
        chk("rst_full",     bus.fifo_full, 1'b0);
        chk("rst_ovf",      bus.overflow, 1'b0);
        chk("rst_seqerr",   bus.seq_err, 1'b0);
        chk("rst_sum",      bus.pkt_sum, 8'h00);
        chk("rst_sumvalid", bus.pkt_sum_valid, 1'b0);
        rst = 1'b0;
        tick(1);

        // Two full words, end of packet lands on a word boundary
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(8'h11 * i));
        send_eop();
        tick(3);
        chk("t1_count", mq_d.size(), 2);
        expect_word("t1_w0", 32'h44332211, 1'b0, c);
        expect_word("t1_w1", 32'h88776655, 1'b1, c);
        chk("t1_seqerr", bus.seq_err, 1'b0);

        // Partial final word goes through both flush states
        do_reset();
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        send_eop();
        e = cyc;
        tick(4);
        chk("t2_count", mq_d.size(), 2);
        expect_word("t2_w0", 32'h04030201, 1'b0, c);
        expect_word("t2_w1", 32'h00000605, 1'b1, c);
        chk("t2_latency", c - e, 2);

        // Reset mid-packet and mid-flush discards everything in progress
        do_reset();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_eop();
        tick(3);
        chk("t3_count", mq_d.size(), 1);
        expect_word("t3_w0", 32'hEFBEADDE, 1'b1, c);
        for (int i = 1; i <= 5; i++) send_byte(8'(8'h30 + i));
        send_eop();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        chk("t3_flush_rst_count", mq_d.size(), 0);

        // Byte arriving during FLUSH1 is dropped and flagged
        do_reset();
        for (int i = 1; i <= 5; i++) send_byte(8'(8'hA0 + i));
        bus.rxd_endofpacket = 1'b1;
        tick(1);
        bus.rxd_endofpacket = 1'b0;
        bus.rxd_data        = 8'hEE;
        bus.rxd_data_ready  = 1'b1;
        tick(1);
        bus.rxd_data_ready  = 1'b0;
        tick(4);
        chk("t4_seqerr", bus.seq_err, 1'b1);
        chk("t4_count", mq_d.size(), 2);
        expect_word("t4_w0", 32'hA4A3A2A1, 1'b0, c);
        expect_word("t4_w1", 32'h000000A5, 1'b1, c);
        chk("t4_ovf", bus.overflow, 1'b0);

        // Checksum of FF,02,10 is 11; bytes end exactly at lane 3 with nothing pending
        do_reset();
        sumv_n = 0;
        send_byte(8'hFF);
        send_byte(8'h02);
        send_byte(8'h10);
        send_eop();
        tick(3);
        chk("t5_count", mq_d.size(), 1);
        expect_word("t5_w0", 32'h001002FF, 1'b1, c);
`ifdef UART_PKT_CHECKSUM_EN
        chk("t5_sum_pulses", sumv_n, 1);
        chk("t5_sum", sumv_v, 8'h11);
`else
        chk("t5_sum_pulses", sumv_n, 0);
`endif

        // Overflow with a stalled consumer, then drain
        do_reset();
        bus.word_ready = 1'b0;
        for (int i = 1; i <= 40; i++) send_byte(8'(i));
        send_eop();
        tick(2);
        chk("t6_full",  bus.fifo_full, 1'b1);
        chk("t6_ovf",   bus.overflow, 1'b1);
        chk("t6_valid", bus.word_valid, 1'b1);
        chk("t6_head",  bus.word_data, 32'h04030201);
        chk("t6_hlast", bus.word_last, 1'b0);
        tick(5);
        chk("t6_hold",  bus.word_data, 32'h04030201);
        bus.word_ready = 1'b1;
        tick(12);
        chk("t6_count", mq_d.size(), 8);
        for (int k = 0; k < 8; k++)
            expect_word("t6_drain",
                        {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, 1'b0, c);
        chk("t6_empty",     bus.word_valid, 1'b0);
        chk("t6_notfull",   bus.fifo_full, 1'b0);
        chk("t6_ovf_stick", bus.overflow, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
